sram_match_scheduler: RTL and testbench
=======================================

# sram_match_scheduler

Central scheduler for the per-port write-side SRAM matchers. Each cycle it hands every port a distinct SRAM index to evaluate, so no two matchers probe the same SRAM in the same cycle. It reports whether that SRAM is free. It also arbitrates lock requests from ports whose matcher has chosen a best SRAM, granting exclusive ownership until the port releases it. It sits between the port matchers and the SRAM bank status logic.

## Interface
- `NUM_PORTS`, default 16: number of write ports; must be ≤ `NUM_SRAMS`.
- `NUM_SRAMS`, default 32: number of shared SRAMs; power of two.
- `SW`, default 5: SRAM index width, log2(`NUM_SRAMS`).
- `PW`, default 4: port index width, log2(`NUM_PORTS`).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `match_enable`  in  `NUM_PORTS`  port p matcher is scanning.
- `match_sram`  out  `NUM_PORTS*SW`  SRAM index port p evaluates this cycle; slice [p*SW +: SW].
- `accessible`  out  `NUM_PORTS`  SRAM at `match_sram[p]` is not locked by any port.
- `lock_req`  in  `NUM_PORTS`  single-cycle request by port p to own `lock_sram[p]`.
- `lock_sram`  in  `NUM_PORTS*SW`  SRAM requested by port p.
- `lock_gnt`  out  `NUM_PORTS`  one-cycle pulse: request granted.
- `lock_rej`  out  `NUM_PORTS`  one-cycle pulse: request refused.
- `release`  in  `NUM_PORTS`  port p gives up its owned SRAM.
- `port_holding`  out  `NUM_PORTS`  port p currently owns an SRAM.
- `sram_busy`  out  `NUM_SRAMS`  SRAM s is locked.

## Operation
- Scan offset `ofs` (SW bits) increments by 1 every cycle and wraps from `NUM_SRAMS-1` to 0. It runs regardless of `match_enable`.
- `match_sram[p] = (p + ofs) mod NUM_SRAMS` (combinational from `ofs`). Indices are pairwise distinct in every cycle, and every port visits every SRAM once per `NUM_SRAMS` cycles.
- `accessible[p] = ~sram_busy[match_sram[p]]` (combinational, same cycle as `match_sram`).
- State:
  - `busy[s]`
  - `owner[s]` (PW bits)
  - `hold[p]`
  - `held[p]` (SW bits)
  - round-robin pointer `rr` (PW bits)
- Release handling, each cycle, first:
  - `release[p]` with `hold[p]=1` clears `busy[held[p]]` and `hold[p]`.
  - `release[p]` with `hold[p]=0` is ignored.
- Request evaluation uses the post-release view. A request from port p is eligible iff:
  - `hold[p]=0` after release, and
  - `busy[lock_sram[p]]=0` after release.
- Ineligible requests get `lock_rej`.
- For each SRAM with ≥1 eligible request, the winner is the first requesting port at or after `rr` in increasing order, wrapping. Other requesters get `lock_rej`.
- On a grant:
  - set `busy`, `owner=p`, `hold[p]=1`, `held[p]=lock_sram[p]`.
  - pulse `lock_gnt[p]`.
- `rr` ← (lowest-index granted port in this cycle + 1) mod `NUM_PORTS`; unchanged if there are no grants.
- A port may own at most one SRAM.
- `match_enable` only gates nothing internally; it is informational. Requests are honoured regardless.

## Timing
- Reset values: `ofs=0` (so `match_sram[p]=p`), `busy=0`, `hold=0`, `rr=0`, `lock_gnt=0`, `lock_rej=0`, `accessible` all 1.
- Request sampled in cycle N. `lock_gnt`/`lock_rej` pulse in cycle N+1, for exactly one cycle. `sram_busy`/`port_holding` update visible in N+1.
- Release sampled in cycle N. `sram_busy` is clear in N+1, and `accessible` reflects that in N+1.
- Simultaneous release and request on the same SRAM: the request can be granted, with the grant in N+1 and busy remaining 1.
- Same-port release plus request in one cycle: the old SRAM is freed and the new request is evaluated.
- Every `lock_req` bit yields exactly one of `lock_gnt`/`lock_rej`; never both, never neither.
- Reset asserted mid-operation: all ownership is dropped next cycle and pending pulses are suppressed.

## Test plan
- Scan rotation: from reset, run 33 cycles → `match_sram[3]` = 3,4,…,31,0,1,2,3; in any cycle all 16 indices are distinct.
- Single lock:
  - port 2 requests SRAM 7 in cycle N → `lock_gnt[2]`=1 in N+1, `sram_busy[7]`=1.
  - Port 9 sees `accessible`=0 when `match_sram[9]`=7.
- Contention:
  - `rr`=0; ports 1 and 5 request SRAM 10 → `lock_gnt[1]`, `lock_rej[5]`, `rr`=2.
  - Repeat after release with `rr`=2 → port 5 wins.
- Double hold: port 4 owns SRAM 3 and requests SRAM 8 without release → `lock_rej[4]`; SRAM 8 stays free.
- Release/request overlap:
  - port 0 releases SRAM 12 while port 6 requests 12 → `lock_gnt[6]`, `sram_busy[12]` stays 1, `port_holding[0]`=0.
- Reset mid-hold: three SRAMs locked, assert `rst` one cycle → `sram_busy`=0, `port_holding`=0, `match_sram[p]`=p.

Source files
------------

// File: rtl/sram_match_scheduler_if.sv
// Bundle between the per-port write-side SRAM matchers and the central
// match scheduler: scan indices, free flags, lock request/response and
// ownership status.
interface sram_match_scheduler_if #(
    parameter int NUM_PORTS = 16,
    parameter int NUM_SRAMS = 32,
    parameter int SW        = 5,
    parameter int PW        = 4
);
    // Matcher -> scheduler
    logic [NUM_PORTS-1:0]    match_enable;
    logic [NUM_PORTS-1:0]    lock_req;
    logic [NUM_PORTS*SW-1:0] lock_sram;
    logic [NUM_PORTS-1:0]    release_req;

    // Scheduler -> matcher
    logic [NUM_PORTS*SW-1:0] match_sram;
    logic [NUM_PORTS-1:0]    accessible;
    logic [NUM_PORTS-1:0]    lock_gnt;
    logic [NUM_PORTS-1:0]    lock_rej;
    logic [NUM_PORTS-1:0]    port_holding;
    logic [NUM_SRAMS-1:0]    sram_busy;

    // Port-matcher side
    modport master (
        output match_enable, lock_req, lock_sram, release_req,
        input  match_sram, accessible, lock_gnt, lock_rej, port_holding, sram_busy
    );

    // Scheduler side
    modport slave (
        input  match_enable, lock_req, lock_sram, release_req,
        output match_sram, accessible, lock_gnt, lock_rej, port_holding, sram_busy
    );
endinterface

// File: rtl/sram_match_scheduler.sv
// Central SRAM match scheduler. A rotating scan offset gives every port a
// distinct SRAM index each cycle, and a round-robin lock arbiter grants
// exclusive SRAM ownership to ports until they release it.
//
// Note: match_enable is informational only; it gates nothing inside.
module sram_match_scheduler #(
    parameter int NUM_PORTS = 16,
    parameter int NUM_SRAMS = 32,
    parameter int SW        = 5,
    parameter int PW        = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sram_match_scheduler_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0]                  r_ofs;
    logic [NUM_SRAMS-1:0]           r_busy;
    logic [NUM_SRAMS-1:0][PW-1:0]   r_owner;
    logic [NUM_PORTS-1:0]           r_hold;
    logic [NUM_PORTS-1:0][SW-1:0]   r_held;
    logic [PW-1:0]                  r_rr;
    logic [NUM_PORTS-1:0]           r_gnt;
    logic [NUM_PORTS-1:0]           r_rej;

    // ------------------------------------------------------------------
    // Combinational views
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0][SW-1:0]   w_scan_idx;
    logic [NUM_PORTS*SW-1:0]        w_match_sram;
    logic [NUM_PORTS-1:0]           w_accessible;
    logic [NUM_PORTS-1:0][SW-1:0]   w_req_sram;

    logic [NUM_SRAMS-1:0]           w_busy_post;
    logic [NUM_PORTS-1:0]           w_hold_post;
    logic [NUM_PORTS-1:0][PW-1:0]   w_dist;
    logic [NUM_PORTS-1:0]           w_elig;
    logic [NUM_PORTS-1:0]           w_gnt;
    logic [NUM_PORTS-1:0]           w_rej;

    logic [NUM_SRAMS-1:0]           w_busy_next;
    logic [NUM_SRAMS-1:0][PW-1:0]   w_owner_next;
    logic [NUM_PORTS-1:0]           w_hold_next;
    logic [NUM_PORTS-1:0][SW-1:0]   w_held_next;
    logic [PW-1:0]                  w_rr_next;

    // Scan index per port, its free flag, and unpacked request targets.
    always_comb begin
        w_scan_idx   = '0;
        w_match_sram = '0;
        w_accessible = '0;
        w_req_sram   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            // SW-bit addition wraps modulo NUM_SRAMS (a power of two).
            w_scan_idx[p]             = SW'(p) + r_ofs;
            w_match_sram[p*SW +: SW]  = w_scan_idx[p];
            w_accessible[p]           = ~r_busy[w_scan_idx[p]];
            w_req_sram[p]             = bus.lock_sram[p*SW +: SW];
        end
    end

    // Apply releases, arbitrate eligible lock requests round-robin, and
    // form the next ownership state.
    always_comb begin
        // Releases first: the requests below see the freed SRAMs.
        w_busy_post = r_busy;
        w_hold_post = r_hold;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.release_req[p] && r_hold[p] &&
                (r_owner[r_held[p]] == PW'(p))) begin
                w_busy_post[r_held[p]] = 1'b0;
                w_hold_post[p]         = 1'b0;
            end else begin
                w_hold_post[p]         = r_hold[p];
            end
        end

        // Priority distance from the round-robin pointer; PW-bit
        // subtraction wraps modulo NUM_PORTS.
        w_dist = '0;
        w_elig = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_dist[p] = PW'(p) - r_rr;
            w_elig[p] = bus.lock_req[p] & ~w_hold_post[p] &
                        ~w_busy_post[w_req_sram[p]];
        end

        // An eligible port wins unless a closer eligible port targets the
        // same SRAM.
        w_gnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_gnt[p] = w_elig[p];
            for (int q = 0; q < NUM_PORTS; q++) begin
                w_gnt[p] = w_gnt[p] & ~(w_elig[q] &
                           (w_req_sram[q] == w_req_sram[p]) &
                           (w_dist[q] < w_dist[p]));
            end
        end
        // Every request that is not granted is refused.
        w_rej = bus.lock_req & ~w_gnt;

        // Commit grants on top of the post-release view.
        w_busy_next  = w_busy_post;
        w_owner_next = r_owner;
        w_hold_next  = w_hold_post;
        w_held_next  = r_held;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
                w_busy_next[w_req_sram[p]]  = 1'b1;
                w_owner_next[w_req_sram[p]] = PW'(p);
                w_hold_next[p]              = 1'b1;
                w_held_next[p]              = w_req_sram[p];
            end else begin
                w_held_next[p]              = r_held[p];
            end
        end

        // Pointer moves past the lowest-index grant; scanning downward
        // leaves the lowest one as the final assignment.
        w_rr_next = r_rr;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (w_gnt[p]) begin
                w_rr_next = PW'(p) + PW'(1);
            end else begin
                w_rr_next = w_rr_next;
            end
        end
    end

    // Register scan offset, ownership state and one-cycle response pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ofs   <= '0;
            r_busy  <= '0;
            r_owner <= '0;
            r_hold  <= '0;
            r_held  <= '0;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_rej   <= '0;
        end else begin
            r_ofs   <= r_ofs + SW'(1);
            r_busy  <= w_busy_next;
            r_owner <= w_owner_next;
            r_hold  <= w_hold_next;
            r_held  <= w_held_next;
            r_rr    <= w_rr_next;
            r_gnt   <= w_gnt;
            r_rej   <= w_rej;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.match_sram   = w_match_sram;
    assign bus.accessible   = w_accessible;
    assign bus.lock_gnt     = r_gnt;
    assign bus.lock_rej     = r_rej;
    assign bus.port_holding = r_hold;
    assign bus.sram_busy    = r_busy;

endmodule

// File: tb/tb_sram_match_scheduler.sv
// Scoreboard bench for sram_match_scheduler: directed scenarios followed by
// random traffic, checked against a sequential reference model.
module tb_sram_match_scheduler;

    localparam int NP = 16;
    localparam int NS = 32;
    localparam int SW = 5;
    localparam int PW = 4;

    logic clk;
    logic rst;

    sram_match_scheduler_if #(.NUM_PORTS(NP), .NUM_SRAMS(NS), .SW(SW), .PW(PW)) bus ();

    sram_match_scheduler #(.NUM_PORTS(NP), .NUM_SRAMS(NS), .SW(SW), .PW(PW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] gnt;
        logic [NP-1:0] rej;
        logic [NP-1:0] hold;
        logic [NS-1:0] busy;
        int            ofs;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit m_busy [NS];
    bit m_hold [NP];
    int m_held [NP];
    int m_rr;
    int m_ofs;

    int t_sram [NP];

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of the model: releases, then requests served in round-robin
    // order, each grant immediately claiming its SRAM.
    task automatic model_step(input logic rst_v, input logic [NP-1:0] req, input logic [NP-1:0] rel);
        exp_t e;
        int   p;
        int   lowest;
        e.gnt = '0;
        e.rej = '0;
        if (rst_v) begin
            for (int s = 0; s < NS; s++) m_busy[s] = 1'b0;
            for (int i = 0; i < NP; i++) begin m_hold[i] = 1'b0; m_held[i] = 0; end
            m_rr  = 0;
            m_ofs = 0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (rel[i] && m_hold[i]) begin
                    m_busy[m_held[i]] = 1'b0;
                    m_hold[i] = 1'b0;
                end
            end
            lowest = -1;
            for (int k = 0; k < NP; k++) begin
                p = (m_rr + k) % NP;
                if (req[p]) begin
                    if (!m_hold[p] && !m_busy[t_sram[p] % NS]) begin
                        m_busy[t_sram[p] % NS] = 1'b1;
                        m_hold[p] = 1'b1;
                        m_held[p] = t_sram[p] % NS;
                        e.gnt[p]  = 1'b1;
                        if (lowest < 0 || p < lowest) lowest = p;
                    end else begin
                        e.rej[p] = 1'b1;
                    end
                end
            end
            if (lowest >= 0) m_rr = (lowest + 1) % NP;
            m_ofs = (m_ofs + 1) % NS;
        end
        for (int s = 0; s < NS; s++) e.busy[s] = m_busy[s];
        for (int i = 0; i < NP; i++) e.hold[i] = m_hold[i];
        e.ofs = m_ofs;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus on the falling edge and queue its result.
    task automatic apply(input logic rst_v, input logic [NP-1:0] req, input logic [NP-1:0] rel);
        @(negedge clk);
        rst             = rst_v;
        bus.lock_req    = req;
        bus.release_req = rel;
        bus.match_enable = NP'($urandom);
        for (int i = 0; i < NP; i++) begin
            logic [31:0] v;
            v = t_sram[i];
            bus.lock_sram[i*SW +: SW] = v[SW-1:0];
        end
        model_step(rst_v, req, rel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, '0, '0);
    endtask

    // Monitor: after every rising edge, pop the expectation and compare.
    initial begin
        exp_t                 e;
        logic [NP*SW-1:0]     e_ms;
        logic [NP-1:0]        e_acc;
        logic [31:0]          idx;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NP; p++) begin
                    idx = (p + e.ofs) % NS;
                    e_ms[p*SW +: SW] = idx[SW-1:0];
                    e_acc[p] = ~e.busy[idx[SW-1:0]];
                end
                cmp("lock_gnt",     128'(bus.lock_gnt),     128'(e.gnt));
                cmp("lock_rej",     128'(bus.lock_rej),     128'(e.rej));
                cmp("sram_busy",    128'(bus.sram_busy),    128'(e.busy));
                cmp("port_holding", 128'(bus.port_holding), 128'(e.hold));
                cmp("match_sram",   128'(bus.match_sram),   128'(e_ms));
                cmp("accessible",   128'(bus.accessible),   128'(e_acc));
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [NP-1:0] req;
        logic [NP-1:0] rel;
        rst              = 1'b1;
        bus.lock_req     = '0;
        bus.release_req  = '0;
        bus.lock_sram    = '0;
        bus.match_enable = '0;
        for (int i = 0; i < NP; i++) t_sram[i] = 0;

        // Reset, then a full scan rotation plus one.
        apply(1'b1, '0, '0);
        idle(33);

        // Single lock: port 2 takes SRAM 7; idle so every port scans it.
        t_sram[2] = 7;
        apply(1'b0, 16'h0004, '0);
        idle(32);
        apply(1'b0, '0, 16'h0004);

        // Contention on SRAM 10 from rr=0, then again from rr=2.
        apply(1'b1, '0, '0);
        t_sram[1] = 10;
        t_sram[5] = 10;
        apply(1'b0, 16'h0022, '0);
        apply(1'b0, '0, 16'h0002);
        apply(1'b0, 16'h0022, '0);
        apply(1'b0, '0, 16'h0020);

        // Double hold: port 4 owns SRAM 3 and asks for SRAM 8.
        t_sram[4] = 3;
        apply(1'b0, 16'h0010, '0);
        t_sram[4] = 8;
        apply(1'b0, 16'h0010, '0);
        // Same-port release plus new request.
        apply(1'b0, 16'h0010, 16'h0010);
        apply(1'b0, '0, 16'h0010);

        // Release/request overlap on SRAM 12.
        t_sram[0] = 12;
        t_sram[6] = 12;
        apply(1'b0, 16'h0001, '0);
        apply(1'b0, 16'h0040, 16'h0001);
        apply(1'b0, '0, 16'h0040);

        // Reset in the middle of three holds.
        t_sram[3] = 20;
        t_sram[4] = 21;
        t_sram[5] = 22;
        apply(1'b0, 16'h0038, '0);
        apply(1'b1, 16'h0001, '0);
        idle(2);

        // Random traffic with a narrow SRAM range for frequent contention.
        for (int c = 0; c < 3000; c++) begin
            req = '0;
            rel = '0;
            for (int i = 0; i < NP; i++) begin
                req[i] = ($urandom_range(0, 99) < 30);
                rel[i] = ($urandom_range(0, 99) < 20);
                t_sram[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                                       : int'($urandom_range(0, NS - 1));
            end
            apply(($urandom_range(0, 199) == 0), req, rel);
        end

        @(posedge clk);
        #2;
        cmp("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
